// File: rtl/countdown_timer_if.sv
// Control/status bundle between the alarm FSM and the seconds countdown timer.
// The controller side requests a (re)start with an interval; the timer reports progress and expiry.
interface countdown_timer_if #(
  parameter int WIDTH = 4
);
  logic             start_timer;
  logic [WIDTH-1:0] value;
  logic             one_hz_enable;
  logic [WIDTH-1:0] countdown;
  logic             busy;
  logic             expired;

  modport master (
    output start_timer,
    output value,
    input  one_hz_enable,
    input  countdown,
    input  busy,
    input  expired
  );

  modport slave (
    input  start_timer,
    input  value,
    output one_hz_enable,
    output countdown,
    output busy,
    output expired
  );
endinterface

// File: rtl/countdown_timer.sv
// Seconds countdown timer with its own free-running 1 Hz prescaler.
// A start request latches the interval and realigns the prescaler; expiry is a one-cycle pulse.
module countdown_timer #(
  parameter int CLK_HZ = 25_000_000,
  parameter int WIDTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  countdown_timer_if.slave  tmr
);
  localparam int              PW      = $clog2(CLK_HZ);
  localparam logic [PW-1:0]   PRE_MAX = PW'(CLK_HZ - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg;
  logic [PW-1:0]    pre_reg;
  logic [WIDTH-1:0] countdown_reg;
  logic             busy_reg;
  logic             expired_reg;
  logic             one_hz_reg;
  logic             tick;

  assign tick = (pre_reg == PRE_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      pre_reg       <= '0;
      countdown_reg <= '0;
      busy_reg      <= 1'b0;
      expired_reg   <= 1'b0;
      one_hz_reg    <= 1'b0;
    end else begin
      one_hz_reg  <= tick;
      expired_reg <= 1'b0;

      // A start realigns the second boundary so the first tick is a full period away.
      if (tmr.start_timer || tick) begin
        pre_reg <= '0;
      end else begin
        pre_reg <= pre_reg + PW'(1);
      end

      if (tmr.start_timer) begin
        countdown_reg <= tmr.value;
        if (tmr.value != '0) begin
          state_reg <= RUN;
          busy_reg  <= 1'b1;
        end else begin
          state_reg   <= IDLE;
          busy_reg    <= 1'b0;
          expired_reg <= 1'b1;
        end
      end else begin
        case (state_reg)
          RUN: begin
            if (tick) begin
              if (countdown_reg != WIDTH'(1)) begin
                countdown_reg <= countdown_reg - WIDTH'(1);
              end else begin
                countdown_reg <= '0;
                expired_reg   <= 1'b1;
                busy_reg      <= 1'b0;
                state_reg     <= IDLE;
              end
            end
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign tmr.one_hz_enable = one_hz_reg;
  assign tmr.countdown     = countdown_reg;
  assign tmr.busy          = busy_reg;
  assign tmr.expired       = expired_reg;
endmodule
